// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART receive-path constants: character framing and derived timeout defaults.
package uart_rx_fifo_pkg;

  localparam int unsigned DEF_DATA_BITS     = 8;
  localparam int unsigned OVERSAMPLE        = 16;
  localparam int unsigned FRAME_BITS        = 10;
  localparam int unsigned TIMEOUT_CHARS     = 4;
  localparam int unsigned DEF_TIMEOUT_TICKS = TIMEOUT_CHARS * FRAME_BITS * OVERSAMPLE;
  localparam int unsigned DEF_DEPTH         = 16;
  localparam int unsigned DEF_THRESH        = 8;

endpackage

// File: rtl/uart_fifo_ram.sv
// DEPTH x DATA_BITS storage: one synchronous write port, one asynchronous read port, no reset.
module uart_fifo_ram #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AW        = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [AW-1:0]        i_waddr,
  input  logic [DATA_BITS-1:0] i_wdata,
  input  logic [AW-1:0]        i_raddr,
  output logic [DATA_BITS-1:0] o_rdata_c
);

  logic [DATA_BITS-1:0] r_mem [DEPTH];

  // Write port; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Show-ahead read straight from the array.
  assign o_rdata_c = r_mem[i_raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: FIFO, level/threshold status,
// sticky overflow/framing flags and a character-timeout indication.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned DATA_BITS     = DEF_DATA_BITS,
  parameter int unsigned DEPTH         = DEF_DEPTH,
  parameter int unsigned THRESH        = DEF_THRESH,
  parameter int unsigned TIMEOUT_TICKS = DEF_TIMEOUT_TICKS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     baud_tick,
  input  logic [DATA_BITS-1:0]     wr_data,
  input  logic                     wr_valid,
  input  logic                     wr_ferr,
  output logic [DATA_BITS-1:0]     rd_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  input  logic                     flush,
  input  logic                     clr_status,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     thresh,
  output logic                     overflow,
  output logic                     ferr_seen,
  output logic                     timeout
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_TICKS + 1);

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic          r_rd_valid;
  logic          r_full;
  logic          r_thresh;
  logic          r_overflow;
  logic          r_ferr_seen;
  logic          r_ferr_d;
  logic          r_timeout;
  logic [TW-1:0] r_tcnt;

  logic          w_pop;
  logic          w_wr_en;
  logic          w_rd_en;
  logic          w_drop;
  logic          w_ferr_rise;
  logic          w_tmo_clr;
  logic          w_tmo_hit;
  logic [LW-1:0] w_level_nxt;

  assign w_pop       = r_rd_valid & rd_ready;
  assign w_wr_en     = wr_valid & (~r_full | w_pop) & ~flush;
  assign w_rd_en     = w_pop & ~flush;
  assign w_drop      = wr_valid & r_full & ~w_pop & ~flush;
  assign w_ferr_rise = wr_ferr & ~r_ferr_d;
  assign w_tmo_clr   = flush | wr_valid | w_pop | ~r_rd_valid;
  assign w_tmo_hit   = baud_tick & (r_tcnt == TW'(TIMEOUT_TICKS - 1));

  // Next occupancy: flush wins, otherwise +1 push-only, -1 pop-only.
  always_comb begin
    w_level_nxt = r_level;
    if (flush) begin
      w_level_nxt = '0;
    end else if (w_wr_en && !w_rd_en) begin
      w_level_nxt = r_level + LW'(1);
    end else if (!w_wr_en && w_rd_en) begin
      w_level_nxt = r_level - LW'(1);
    end
  end

  // Pointers and registered occupancy-derived status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_rd_valid <= 1'b0;
      r_full     <= 1'b0;
      r_thresh   <= 1'b0;
    end else begin
      if (flush) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_wr_en) r_wptr <= r_wptr + AW'(1);
        if (w_rd_en) r_rptr <= r_rptr + AW'(1);
      end
      r_level    <= w_level_nxt;
      r_rd_valid <= (w_level_nxt != '0);
      r_full     <= (w_level_nxt == LW'(DEPTH));
      r_thresh   <= (w_level_nxt >= LW'(THRESH));
    end
  end

  // Sticky flags; a same-cycle set event beats clr_status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_ferr_seen <= 1'b0;
      r_ferr_d    <= 1'b0;
    end else begin
      r_overflow  <= w_drop | (r_overflow & ~clr_status);
      r_ferr_seen <= w_ferr_rise | (r_ferr_seen & ~clr_status);
      r_ferr_d    <= wr_ferr;
    end
  end

  // Idle tick counter; timeout fires on the final tick of the idle window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tcnt    <= '0;
      r_timeout <= 1'b0;
    end else if (w_tmo_clr) begin
      r_tcnt    <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (baud_tick && (r_tcnt != TW'(TIMEOUT_TICKS - 1))) begin
        r_tcnt <= r_tcnt + TW'(1);
      end
      if (w_tmo_hit) begin
        r_timeout <= 1'b1;
      end
    end
  end

  uart_fifo_ram #(
    .DATA_BITS (DATA_BITS),
    .DEPTH     (DEPTH),
    .AW        (AW)
  ) u_ram (
    .clk       (clk),
    .i_we      (w_wr_en),
    .i_waddr   (r_wptr),
    .i_wdata   (wr_data),
    .i_raddr   (r_rptr),
    .o_rdata_c (rd_data)
  );

  assign rd_valid  = r_rd_valid;
  assign level     = r_level;
  assign full      = r_full;
  assign thresh    = r_thresh;
  assign overflow  = r_overflow;
  assign ferr_seen = r_ferr_seen;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized and directed bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int unsigned DW     = 8;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned THRESH = 8;
  localparam int unsigned TMO    = 640;
  localparam int unsigned LW     = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          baud_tick = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ferr = 1'b0;
  logic          rd_ready = 1'b0;
  logic          flush = 1'b0;
  logic          clr_status = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [LW-1:0] level;
  logic          full;
  logic          thresh;
  logic          overflow;
  logic          ferr_seen;
  logic          timeout;

  uart_rx_fifo #(
    .DATA_BITS     (DW),
    .DEPTH         (DEPTH),
    .THRESH        (THRESH),
    .TIMEOUT_TICKS (TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .baud_tick  (baud_tick),
    .wr_data    (wr_data),
    .wr_valid   (wr_valid),
    .wr_ferr    (wr_ferr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .flush      (flush),
    .clr_status (clr_status),
    .level      (level),
    .full       (full),
    .thresh     (thresh),
    .overflow   (overflow),
    .ferr_seen  (ferr_seen),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [DW-1:0] q[$];
  bit  m_ovf, m_ferr, m_ferr_d, m_tmo;
  int  m_idle;
  int  n_pass = 0;
  int  n_checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 0; m_ferr = 0; m_ferr_d = 0; m_tmo = 0; m_idle = 0;
  endtask

  // One clock of the reference model, applied to the inputs present at the edge.
  task automatic model_step();
    int sz;
    bit pop, drop, act;
    sz   = q.size();
    pop  = (sz != 0) && rd_ready;
    drop = 0;
    act  = flush || wr_valid || pop || (sz == 0);
    if (flush) q.delete();
    else begin
      if (pop) q.delete(0);
      if (wr_valid) begin
        if (sz == int'(DEPTH) && !pop) drop = 1;
        else q.push_back(wr_data);
      end
    end
    m_ovf    = drop || (m_ovf && !clr_status);
    m_ferr   = (wr_ferr && !m_ferr_d) || (m_ferr && !clr_status);
    m_ferr_d = wr_ferr;
    if (act) begin
      m_idle = 0;
      m_tmo  = 0;
    end else if (baud_tick) begin
      m_idle++;
      if (m_idle >= int'(TMO)) m_tmo = 1;
    end
  endtask

  task automatic compare_all();
    check("level",     32'(level),     32'(q.size()));
    check("rd_valid",  32'(rd_valid),  32'(q.size() != 0));
    check("full",      32'(full),      32'(q.size() == int'(DEPTH)));
    check("thresh",    32'(thresh),    32'(q.size() >= int'(THRESH)));
    check("overflow",  32'(overflow),  32'(m_ovf));
    check("ferr_seen", 32'(ferr_seen), 32'(m_ferr));
    check("timeout",   32'(timeout),   32'(m_tmo));
    if (q.size() != 0) check("rd_data", 32'(rd_data), 32'(q[0]));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle_in();
    wr_valid = 0; rd_ready = 0; flush = 0; clr_status = 0;
  endtask

  task automatic push(input logic [DW-1:0] d);
    wr_valid = 1; wr_data = d;
    cyc();
    wr_valid = 0;
  endtask

  task automatic do_reset();
    idle_in();
    wr_ferr = 0;
    #2 rst_n = 0;
    #2;
    model_reset();
    compare_all();
    @(posedge clk); #1;
    compare_all();
    rst_n = 1;
  endtask

  initial begin
    model_reset();
    do_reset();

    // Three spaced pushes, then drain in order.
    for (int i = 0; i < 3; i++) begin
      push(8'h41 + 8'(i));
      repeat (9) cyc();
    end
    rd_ready = 1;
    repeat (5) cyc();
    rd_ready = 0;

    // Overfill by one, drain, clear the sticky overflow.
    for (int i = 0; i < 17; i++) push(8'(i));
    cyc();
    rd_ready = 1;
    repeat (18) cyc();
    rd_ready = 0;
    clr_status = 1; cyc(); clr_status = 0;
    cyc();

    // Push and pop together while full.
    for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
    wr_valid = 1; wr_data = 8'hAA; rd_ready = 1;
    cyc();
    wr_valid = 0;
    repeat (17) cyc();
    rd_ready = 0;

    // Threshold crossing up and back down.
    for (int i = 0; i < 8; i++) push(8'(8'h60 + i));
    rd_ready = 1; cyc(); rd_ready = 0;
    rd_ready = 1; repeat (8) cyc(); rd_ready = 0;

    // Character timeout with a tick every cycle; then empty FIFO must not time out.
    baud_tick = 1;
    push(8'h77);
    repeat (645) cyc();
    rd_ready = 1; cyc(); rd_ready = 0;
    repeat (700) cyc();
    push(8'h78);
    repeat (5) cyc();
    rd_ready = 1; cyc(); rd_ready = 0;
    baud_tick = 0;

    // Flush with concurrent push at level 5; framing-error edge and clear.
    for (int i = 0; i < 5; i++) push(8'(8'h30 + i));
    flush = 1; wr_valid = 1; wr_data = 8'h55;
    cyc();
    flush = 0; wr_valid = 0;
    cyc();
    wr_ferr = 1; repeat (3) cyc();
    wr_ferr = 0; repeat (3) cyc();
    clr_status = 1; cyc(); clr_status = 0;
    cyc();

    // Randomized traffic in fill-heavy and drain-heavy phases.
    for (int ph = 0; ph < 6; ph++) begin
      for (int c = 0; c < 500; c++) begin
        wr_valid   = ($urandom_range(0, 99) < ((ph % 2 == 0) ? 70 : 25));
        wr_data    = 8'($urandom);
        rd_ready   = ($urandom_range(0, 99) < ((ph % 2 == 0) ? 25 : 70));
        flush      = ($urandom_range(0, 99) < 2);
        clr_status = ($urandom_range(0, 99) < 3);
        baud_tick  = ($urandom_range(0, 99) < 50);
        if ($urandom_range(0, 99) < 5) wr_ferr = ~wr_ferr;
        cyc();
      end
    end
    idle_in();
    baud_tick = 0;

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 6; i++) push(8'(8'hC0 + i));
    wr_valid = 1; wr_data = 8'hEE; wr_ferr = 1;
    #2 rst_n = 0;
    #1;
    model_reset();
    compare_all();
    idle_in();
    wr_ferr = 0;
    @(posedge clk); #1;
    compare_all();
    rst_n = 1;
    repeat (3) cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
